ddrphy_lane_dly_seq: RTL and testbench
======================================

Name: ddrphy_lane_dly_seq

Overview:
Fabric-side sequencer that drives the delay-line control interface of a DDR4 PHY lane controller (DELAY_LINE_SEL/LOAD/DIRECTION/MOVE plus HS_IO_CLK_PAUSE) and consumes its RX/TX out-of-range flags.
- Accepts tap LOAD/MOVE commands from the training engine over a valid/ready handshake.
- Wraps every pulse train in a clean HS_IO_CLK_PAUSE window.
- Shadows the current RX and TX DQS tap positions and reports completion and errors.

Parameters:
RX_INIT_TAP, 8'd1, RX DQS tap value restored by LOAD; must match the lane's RX_DQS_DELAY_VAL
TX_INIT_TAP, 8'd1, TX DQS tap value restored by LOAD; must match the lane's TX_DQS_DELAY_VAL
TAP_MAX, 8'd255, highest legal tap position
PAUSE_SETUP, 4, cycles HS_IO_CLK_PAUSE is high before the first pulse (≥1)
MOVE_GAP, 3, idle cycles after each pulse (≥1)
PAUSE_HOLD, 4, cycles HS_IO_CLK_PAUSE stays high after the last gap (≥1)

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
CMD_VALID  in  1  command valid
CMD_READY  out  1  high only in IDLE
CMD_SEL  in  1  0=RX delay line, 1=TX delay line
CMD_LOAD  in  1  1=LOAD (restore init tap), 0=MOVE
CMD_DIR  in  1  MOVE direction; 1=increment, 0=decrement
CMD_COUNT  in  8  number of MOVE pulses; ignored for LOAD
DELAY_LINE_SEL  out  1  latched CMD_SEL, held for the whole command
DELAY_LINE_DIRECTION  out  1  latched CMD_DIR, held for the whole command
DELAY_LINE_MOVE  out  1  single-cycle move pulse
DELAY_LINE_LOAD  out  1  single-cycle load pulse
HS_IO_CLK_PAUSE  out  1  clock pause request to the lane
RX_DELAY_LINE_OUT_OF_RANGE  in  1  lane RX flag
TX_DELAY_LINE_OUT_OF_RANGE  in  1  lane TX flag
BUSY  out  1  high from accept through the DONE cycle
DONE  out  1  one-cycle completion pulse
ERR  out  1  sticky error for the last command; cleared on the next accept
RX_TAP  out  8  shadow RX tap position
TX_TAP  out  8  shadow TX tap position

Behaviour:
- Reset values: all control/status outputs 0 except CMD_READY=1. RX_TAP=RX_INIT_TAP, TX_TAP=TX_INIT_TAP. Reset during any state returns to IDLE at the next edge; HS_IO_CLK_PAUSE is released in the same cycle.
- All outputs are registered.
- FSM states: IDLE, PRE, PULSE, GAP, POST, DONE.
- IDLE: accept when CMD_VALID & CMD_READY (cycle 0).
  - Latch SEL, DIR, LOAD, COUNT; clear ERR.
  - MOVE with COUNT=0: go to DONE with no pause.
  - Otherwise go to PRE.
- PRE: HS_IO_CLK_PAUSE=1 for cycles 1..PAUSE_SETUP, then PULSE.
- PULSE (one cycle):
  - LOAD: DELAY_LINE_LOAD=1; selected tap ← its INIT value.
  - MOVE: bound check first. If DIR=1 and tap==TAP_MAX, or DIR=0 and tap==0, issue no pulse, set ERR, go to POST. Otherwise DELAY_LINE_MOVE=1, selected tap ±1, remaining count −1.
- GAP: MOVE_GAP cycles.
  - Selected OUT_OF_RANGE is sampled every GAP cycle; if it is 1, set ERR and go to POST (abort).
  - At the end of GAP: go to PULSE if remaining count > 0, else POST. LOAD always goes to POST.
- POST: pause held for PAUSE_HOLD cycles, then DONE.
- DONE: DONE=1 and HS_IO_CLK_PAUSE=0 for one cycle, then IDLE (CMD_READY=1 the following cycle).
- Latency: a MOVE of N pulses with no error has DONE at cycle 1+PAUSE_SETUP+N·(1+MOVE_GAP)+PAUSE_HOLD; LOAD is the N=1 case.
- The non-selected tap and OUT_OF_RANGE input are ignored. CMD_* changes while BUSY have no effect.
- Taps never wrap: they are bounded to 0..TAP_MAX.

Test Plan:
- Reset → CMD_READY=1, RX_TAP=TX_TAP=1, PAUSE/MOVE/LOAD/DONE/ERR=0; assert RESET mid-GAP → IDLE next edge, PAUSE=0, taps back to 1.
- MOVE RX, DIR=1, COUNT=2, defaults → PAUSE high cycles 1–16, MOVE pulses at cycles 5 and 9, SEL=0 and DIR=1 stable throughout, DONE at cycle 17, RX_TAP=3, TX_TAP unchanged.
- LOAD TX after TX_TAP=10 → LOAD pulse at cycle 5, DONE at cycle 13, TX_TAP=1, no MOVE pulse.
- MOVE TX, DIR=0, COUNT=3 from TX_TAP=1 → one pulse (tap 0), second PULSE blocked, ERR=1, POST 4 cycles, DONE, TX_TAP=0.
- MOVE RX, COUNT=5; raise RX_DELAY_LINE_OUT_OF_RANGE during the 2nd GAP → exactly 2 pulses, ERR=1, DONE pulses; raising the TX flag instead → no effect.
- MOVE with COUNT=0 → DONE at cycle 1, no pause; CMD_VALID held high while BUSY → no second accept until CMD_READY returns; ERR cleared on the next accept.

Source files
------------

// File: rtl/ddrphy_lane_dly_seq.sv
// ddrphy_lane_dly_seq
// Fabric-side sequencer for a DDR4 PHY lane delay-line control interface.
// It takes LOAD/MOVE tap commands from the training engine, wraps every
// pulse train in a clean HS_IO_CLK_PAUSE window, shadows the RX/TX DQS tap
// positions and reports completion and errors. Every output is a register;
// each output flop is loaded from the value it must carry in the state being
// entered, so outputs line up with the state they describe.

module ddrphy_lane_dly_seq #(
   parameter logic [7:0]  RX_INIT_TAP = 8'd1,
   parameter logic [7:0]  TX_INIT_TAP = 8'd1,
   parameter logic [7:0]  TAP_MAX     = 8'd255,
   parameter int unsigned PAUSE_SETUP = 4,
   parameter int unsigned MOVE_GAP    = 3,
   parameter int unsigned PAUSE_HOLD  = 4
) (
   input  logic       FAB_CLK,
   input  logic       RESET,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic       CMD_SEL,
   input  logic       CMD_LOAD,
   input  logic       CMD_DIR,
   input  logic [7:0] CMD_COUNT,
   output logic       DELAY_LINE_SEL,
   output logic       DELAY_LINE_DIRECTION,
   output logic       DELAY_LINE_MOVE,
   output logic       DELAY_LINE_LOAD,
   output logic       HS_IO_CLK_PAUSE,
   input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
   input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR,
   output logic [7:0] RX_TAP,
   output logic [7:0] TX_TAP
);

   // Phase counters run from 1 up to these terminal values.
   localparam logic [7:0] SETUP_LAST = 8'(PAUSE_SETUP);
   localparam logic [7:0] GAP_LAST   = 8'(MOVE_GAP);
   localparam logic [7:0] HOLD_LAST  = 8'(PAUSE_HOLD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_PULSE,
      S_GAP,
      S_POST,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] phase_q, phase_d;
   logic [7:0] remCount_q, remCount_d;
   logic       latchSel_q, latchSel_d;
   logic       latchDir_q, latchDir_d;
   logic       latchLoad_q, latchLoad_d;
   logic       err_q, err_d;
   logic       movePulse_q, movePulse_d;
   logic       loadPulse_q, loadPulse_d;
   logic       pause_q, pause_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;
   logic [7:0] rxTap_q, rxTap_d;
   logic [7:0] txTap_q, txTap_d;

   logic       firePulse;
   logic [7:0] curTap;
   logic       atBound;
   logic       selOutOfRange;

   // Only the delay line chosen by the latched select matters; the other
   // tap and the other out-of-range flag are deliberately ignored.
   assign curTap        = latchSel_q ? txTap_q : rxTap_q;
   assign atBound       = latchDir_q ? (curTap == TAP_MAX) : (curTap == 8'd0);
   assign selOutOfRange = latchSel_q ? TX_DELAY_LINE_OUT_OF_RANGE
                                     : RX_DELAY_LINE_OUT_OF_RANGE;

   // Next-state and next-output logic. A transition into PULSE raises
   // firePulse, and the pulse itself (or the bound-check refusal) is decided
   // once, below the case, so PRE->PULSE and GAP->PULSE share one path.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      remCount_d  = remCount_q;
      latchSel_d  = latchSel_q;
      latchDir_d  = latchDir_q;
      latchLoad_d = latchLoad_q;
      err_d       = err_q;
      rxTap_d     = rxTap_q;
      txTap_d     = txTap_q;
      movePulse_d = 1'b0;
      loadPulse_d = 1'b0;
      firePulse   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (CMD_VALID && ready_q) begin
               latchSel_d  = CMD_SEL;
               latchDir_d  = CMD_DIR;
               latchLoad_d = CMD_LOAD;
               remCount_d  = CMD_COUNT;
               err_d       = 1'b0;
               phase_d     = 8'd1;
               if (!CMD_LOAD && (CMD_COUNT == 8'd0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_PRE;
               end
            end
         end

         S_PRE: begin
            if (phase_q == SETUP_LAST) begin
               state_d   = S_PULSE;
               firePulse = 1'b1;
            end else begin
               phase_d = phase_q + 8'd1;
            end
         end

         S_PULSE: begin
            phase_d = 8'd1;
            // A MOVE that was refused at the bound shows no pulse in this
            // cycle; skip the gap and close the pause window straight away.
            if (!latchLoad_q && !movePulse_q) begin
               state_d = S_POST;
            end else begin
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            if (selOutOfRange) begin
               err_d   = 1'b1;
               state_d = S_POST;
               phase_d = 8'd1;
            end else if (phase_q == GAP_LAST) begin
               if (!latchLoad_q && (remCount_q != 8'd0)) begin
                  state_d   = S_PULSE;
                  firePulse = 1'b1;
               end else begin
                  state_d = S_POST;
                  phase_d = 8'd1;
               end
            end else begin
               phase_d = phase_q + 8'd1;
            end
         end

         S_POST: begin
            if (phase_q == HOLD_LAST) begin
               state_d = S_DONE;
            end else begin
               phase_d = phase_q + 8'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (firePulse) begin
         if (latchLoad_q) begin
            loadPulse_d = 1'b1;
            if (latchSel_q) begin
               txTap_d = TX_INIT_TAP;
            end else begin
               rxTap_d = RX_INIT_TAP;
            end
         end else if (atBound) begin
            err_d = 1'b1;
         end else begin
            movePulse_d = 1'b1;
            remCount_d  = remCount_q - 8'd1;
            if (latchSel_q) begin
               txTap_d = latchDir_q ? (txTap_q + 8'd1) : (txTap_q - 8'd1);
            end else begin
               rxTap_d = latchDir_q ? (rxTap_q + 8'd1) : (rxTap_q - 8'd1);
            end
         end
      end

      pause_d = (state_d == S_PRE) || (state_d == S_PULSE) ||
                (state_d == S_GAP) || (state_d == S_POST);
      busy_d  = (state_d != S_IDLE);
      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   // State, datapath and output registers with synchronous reset; reset
   // drops the pause request and restores the init taps on the next edge.
   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         phase_q     <= 8'd0;
         remCount_q  <= 8'd0;
         latchSel_q  <= 1'b0;
         latchDir_q  <= 1'b0;
         latchLoad_q <= 1'b0;
         err_q       <= 1'b0;
         movePulse_q <= 1'b0;
         loadPulse_q <= 1'b0;
         pause_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
         rxTap_q     <= RX_INIT_TAP;
         txTap_q     <= TX_INIT_TAP;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         remCount_q  <= remCount_d;
         latchSel_q  <= latchSel_d;
         latchDir_q  <= latchDir_d;
         latchLoad_q <= latchLoad_d;
         err_q       <= err_d;
         movePulse_q <= movePulse_d;
         loadPulse_q <= loadPulse_d;
         pause_q     <= pause_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
         rxTap_q     <= rxTap_d;
         txTap_q     <= txTap_d;
      end
   end

   assign CMD_READY            = ready_q;
   assign DELAY_LINE_SEL       = latchSel_q;
   assign DELAY_LINE_DIRECTION = latchDir_q;
   assign DELAY_LINE_MOVE      = movePulse_q;
   assign DELAY_LINE_LOAD      = loadPulse_q;
   assign HS_IO_CLK_PAUSE      = pause_q;
   assign BUSY                 = busy_q;
   assign DONE                 = done_q;
   assign ERR                  = err_q;
   assign RX_TAP               = rxTap_q;
   assign TX_TAP               = txTap_q;

endmodule

// File: tb/tb_ddrphy_lane_dly_seq.sv
// tb_ddrphy_lane_dly_seq
// Scoreboard bench for ddrphy_lane_dly_seq. Each command's expected outcome
// (done cycle, pulse counts, pause length, error, final taps) is computed
// from the sequencing rules at command level and queued; an independent
// monitor observes each command from its first BUSY cycle to DONE and
// compares against the head of the queue.

module tb_ddrphy_lane_dly_seq;

   localparam logic [7:0] RxInit = 8'd1;
   localparam logic [7:0] TxInit = 8'd1;
   localparam logic [7:0] TapMax = 8'd20;
   localparam int         Setup  = 4;
   localparam int         Gap    = 3;
   localparam int         Hold   = 4;
   localparam int         Limit  = 300;

   logic       clock = 1'b0;
   logic       reset;
   logic       cmdValid, cmdReady, cmdSel, cmdLoad, cmdDir;
   logic [7:0] cmdCount;
   logic       dlSel, dlDir, dlMove, dlLoad, pause;
   logic       rxOor, txOor;
   logic       busy, done, err;
   logic [7:0] rxTap, txTap;

   always #5 clock = ~clock;

   ddrphy_lane_dly_seq #(
      .RX_INIT_TAP(RxInit),
      .TX_INIT_TAP(TxInit),
      .TAP_MAX    (TapMax),
      .PAUSE_SETUP(Setup),
      .MOVE_GAP   (Gap),
      .PAUSE_HOLD (Hold)
   ) dut (
      .FAB_CLK                   (clock),
      .RESET                     (reset),
      .CMD_VALID                 (cmdValid),
      .CMD_READY                 (cmdReady),
      .CMD_SEL                   (cmdSel),
      .CMD_LOAD                  (cmdLoad),
      .CMD_DIR                   (cmdDir),
      .CMD_COUNT                 (cmdCount),
      .DELAY_LINE_SEL            (dlSel),
      .DELAY_LINE_DIRECTION      (dlDir),
      .DELAY_LINE_MOVE           (dlMove),
      .DELAY_LINE_LOAD           (dlLoad),
      .HS_IO_CLK_PAUSE           (pause),
      .RX_DELAY_LINE_OUT_OF_RANGE(rxOor),
      .TX_DELAY_LINE_OUT_OF_RANGE(txOor),
      .BUSY                      (busy),
      .DONE                      (done),
      .ERR                       (err),
      .RX_TAP                    (rxTap),
      .TX_TAP                    (txTap)
   );

   typedef struct {
      int doneCyc;
      int moves;
      int loads;
      int pauseCyc;
      int errExp;
      int rx;
      int tx;
      int sel;
      int dir;
   } expT;

   expT expQ[$];
   int  checks = 0;
   int  errors = 0;
   int  modelRx = int'(RxInit);
   int  modelTx = int'(TxInit);

   // Single comparison point: every check bumps the counters used in the summary.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: walks the pulse schedule of one command with plain
   // arithmetic and predicts its outcome. oCyc is the command-relative
   // cycle in which a flag is raised on delay line oSel (0 = none).
   task automatic predict(input int sel, input int load, input int dir,
                          input int count, input int oCyc, input int oSel);
      expT e;
      int  tap;
      int  n;
      int  p;
      tap = sel ? modelTx : modelRx;
      n   = load ? 1 : count;
      e.sel = sel; e.dir = dir; e.errExp = 0; e.moves = 0; e.loads = 0;
      e.doneCyc = 1;
      if (!load && count == 0) begin
         e.pauseCyc = 0;
      end else begin
         for (int i = 1; i <= n; i++) begin
            p = 1 + Setup + (i - 1) * (1 + Gap);
            if (load) begin
               tap = sel ? int'(TxInit) : int'(RxInit);
               e.loads++;
            end else if ((dir && tap == int'(TapMax)) || (!dir && tap == 0)) begin
               e.errExp  = 1;
               e.doneCyc = p + 1 + Hold;
               break;
            end else begin
               tap = dir ? tap + 1 : tap - 1;
               e.moves++;
            end
            if (oSel == sel && oCyc > p && oCyc <= p + Gap) begin
               e.errExp  = 1;
               e.doneCyc = oCyc + 1 + Hold;
               break;
            end
            if (i == n) e.doneCyc = p + Gap + 1 + Hold;
         end
         e.pauseCyc = e.doneCyc - 1;
      end
      if (sel) modelTx = tap; else modelRx = tap;
      e.rx = modelRx;
      e.tx = modelTx;
      expQ.push_back(e);
   endtask

   // Present the current command fields with VALID high until accepted.
   task automatic waitAccept(output bit ok);
      ok = 1'b0;
      for (int w = 0; w < Limit && !ok; w++) begin
         if (cmdReady) begin
            @(posedge clock);
            ok = 1'b1;
         end else begin
            @(negedge clock);
         end
      end
   endtask

   // Issue one command; VALID stays high and the command fields are
   // scrambled while the sequencer is busy, and the out-of-range flag is
   // pulsed in cycle oCyc on the chosen line.
   task automatic applyStimulus(input bit sel, input bit load, input bit dir,
                                input logic [7:0] count, input int oCyc, input bit oSel);
      bit ok;
      bit seen;
      predict(int'(sel), int'(load), int'(dir), int'(count), oCyc, int'(oSel));
      @(negedge clock);
      cmdSel = sel; cmdLoad = load; cmdDir = dir; cmdCount = count;
      cmdValid = 1'b1;
      waitAccept(ok);
      if (!ok) begin
         checkOutput("accept timeout", 0, 1);
         void'(expQ.pop_back());
         cmdValid = 1'b0;
         return;
      end
      seen = 1'b0;
      for (int k = 1; k <= Limit && !seen; k++) begin
         @(negedge clock);
         rxOor    = (oCyc == k) && !oSel;
         txOor    = (oCyc == k) && oSel;
         cmdSel   = 1'($urandom);
         cmdLoad  = 1'($urandom);
         cmdDir   = 1'($urandom);
         cmdCount = 8'($urandom);
         if (done) seen = 1'b1;
      end
      cmdValid = 1'b0;
      rxOor    = 1'b0;
      txOor    = 1'b0;
      if (!seen) checkOutput("done timeout", 0, 1);
   endtask

   // Start a long RX MOVE and hit reset in the middle of the first gap.
   task automatic applyResetMidGap();
      bit ok;
      @(negedge clock);
      cmdSel = 1'b0; cmdLoad = 1'b0; cmdDir = 1'b1; cmdCount = 8'd5;
      cmdValid = 1'b1;
      waitAccept(ok);
      checkOutput("reset test accept", int'(ok), 1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clock);
         cmdValid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clock);
      checkOutput("reset mid-gap pause", int'(pause), 0);
      checkOutput("reset mid-gap busy", int'(busy), 0);
      checkOutput("reset mid-gap ready", int'(cmdReady), 1);
      checkOutput("reset mid-gap rx tap", int'(rxTap), int'(RxInit));
      checkOutput("reset mid-gap tx tap", int'(txTap), int'(TxInit));
      @(negedge clock);
      reset   = 1'b0;
      modelRx = int'(RxInit);
      modelTx = int'(TxInit);
   endtask

   // Monitor: tracks each command from its first BUSY cycle, accumulates
   // what the lane interface saw, and scores it against the queue at DONE.
   bit   mActive = 1'b0;
   int   mCyc, mMoves, mLoads, mPause, mSel, mDir, mStable, mReadyBad, mPauseAtDone;
   expT  mExp;

   always @(negedge clock) begin
      if (reset) begin
         mActive = 1'b0;
      end else begin
         if (busy && !mActive) begin
            mActive   = 1'b1;
            mCyc      = 0;
            mMoves    = 0;
            mLoads    = 0;
            mPause    = 0;
            mSel      = int'(dlSel);
            mDir      = int'(dlDir);
            mStable   = 1;
            mReadyBad = 0;
            checkOutput("err cleared on accept", int'(err), 0);
         end
         if (mActive) begin
            mCyc++;
            mMoves += int'(dlMove);
            mLoads += int'(dlLoad);
            mPause += int'(pause);
            if (int'(dlSel) != mSel || int'(dlDir) != mDir) mStable = 0;
            if (cmdReady) mReadyBad = 1;
            if (done) begin
               mPauseAtDone = int'(pause);
               if (expQ.size() == 0) begin
                  checkOutput("unexpected command", expQ.size(), 1);
               end else begin
                  mExp = expQ.pop_front();
                  checkOutput("done cycle", mCyc, mExp.doneCyc);
                  checkOutput("move pulses", mMoves, mExp.moves);
                  checkOutput("load pulses", mLoads, mExp.loads);
                  checkOutput("pause cycles", mPause, mExp.pauseCyc);
                  checkOutput("pause at done", mPauseAtDone, 0);
                  checkOutput("err", int'(err), mExp.errExp);
                  checkOutput("rx tap", int'(rxTap), mExp.rx);
                  checkOutput("tx tap", int'(txTap), mExp.tx);
                  checkOutput("sel", mSel, mExp.sel);
                  checkOutput("dir", mDir, mExp.dir);
                  checkOutput("sel/dir stable", mStable, 1);
                  checkOutput("ready low while busy", mReadyBad, 0);
               end
               mActive = 1'b0;
            end else if (mCyc > Limit) begin
               checkOutput("monitor done timeout", mCyc, Limit);
               mActive = 1'b0;
            end
         end
      end
   end

   // Directed scenarios first, then randomized commands with random flags.
   initial begin
      reset = 1'b1; cmdValid = 1'b0; cmdSel = 1'b0; cmdLoad = 1'b0;
      cmdDir = 1'b0; cmdCount = 8'd0; rxOor = 1'b0; txOor = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("reset ready", int'(cmdReady), 1);
      checkOutput("reset rx tap", int'(rxTap), int'(RxInit));
      checkOutput("reset tx tap", int'(txTap), int'(TxInit));
      checkOutput("reset pause", int'(pause), 0);
      checkOutput("reset move", int'(dlMove), 0);
      checkOutput("reset load", int'(dlLoad), 0);
      checkOutput("reset done", int'(done), 0);
      checkOutput("reset err", int'(err), 0);
      checkOutput("reset busy", int'(busy), 0);
      reset = 1'b0;
      @(negedge clock);

      applyStimulus(1'b0, 1'b0, 1'b1, 8'd2, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd9, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd7, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd5, 11, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd5, 11, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'd0, 7, 1'b1);
      applyResetMidGap();
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd25, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         applyStimulus(1'($urandom), ($urandom_range(0, 3) == 0),
                       1'($urandom), 8'($urandom_range(0, 8)),
                       ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 30)),
                       1'($urandom));
      end

      repeat (3) @(negedge clock);
      checkOutput("pending expectations", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
